// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Owns the program counter, issues one word request
// at a time to instruction memory, buffers returned words in a 2-entry queue
// and hands them to decode as {pc_o, instruction_o} with a one-cycle en_o
// strobe. A redirect from execute flushes the queue and any in-flight fetch.
//
// Optional feature: define FETCH_PERF_CNT_EN to build the delivered-instruction
// and bubble counters; otherwise both count outputs are tied to 0.
//
// Ports:
//   clk            in   1  clock, rising edge
//   reset          in   1  asynchronous, active-high reset
//   stall_i        in   1  decode cannot accept an instruction this cycle
//   redirect_i     in   1  taken branch / jump from execute
//   redirect_pc_i  in  32  redirect target, bits [1:0] ignored
//   imem_req_o     out  1  single-cycle request pulse
//   imem_addr_o    out 32  word-aligned request address
//   imem_rvalid_i  in   1  response strobe for the outstanding request
//   imem_rdata_i   in  32  returned instruction word
//   en_o           out  1  instruction presented and consumed this cycle
//   instruction_o  out 32  head instruction, NOP_INSTR when en_o is 0
//   pc_o           out 32  PC of head instruction, 0 when en_o is 0
//   fetch_count_o  out 32  instructions delivered
//   bubble_count_o out 32  unstalled cycles with nothing delivered
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        en_o,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic [31:0] fetch_count_o,
  output logic [31:0] bubble_count_o
);

  // Encoding is {outstanding, drop}.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b10,
    DRAIN = 2'b11
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;      // PC of the request currently in flight
  logic [1:0]  count;
  logic        head;
  logic [31:0] q_pc    [2];
  logic [31:0] q_instr [2];

  logic        outstanding;
  logic        drop;
  logic        resp;
  logic        pop;
  logic        push;
  logic        req;
  logic        tail;
  logic [2:0]  occupancy;
  logic        unused_bits;

  assign outstanding = (state != IDLE);
  assign drop        = (state == DRAIN);

  // A strobe with nothing in flight (e.g. a response to a request that was
  // cut off by reset) is not a response at all.
  assign resp = imem_rvalid_i & outstanding;

  assign pop  = (count != 2'd0) & ~stall_i & ~redirect_i;
  assign push = resp & ~drop & ~redirect_i;

  // Slots committed after this cycle: queued words, minus the one leaving,
  // plus the word still in flight or the one arriving now.
  assign occupancy = {1'b0, count} - {2'b00, pop}
                   + {2'b00, outstanding & ~resp} + {2'b00, resp};

  // Combinational so that a response can be followed by a back-to-back
  // request in the same cycle; a new request also needs the current one
  // retired so that at most one is ever in flight.
  assign req = ~reset & ~redirect_i & ~drop & (~outstanding | resp)
             & (occupancy < 3'd2);

  assign imem_req_o  = req;
  assign imem_addr_o = fetch_pc;

  // Queue holds at most 2, so the tail is head + count modulo 2.
  assign tail = head ^ count[0];

  assign unused_bits = ^redirect_pc_i[1:0];

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      count    <= 2'd0;
      head     <= 1'b0;
    end else if (redirect_i) begin
      fetch_pc <= {redirect_pc_i[31:2], 2'b00};
      count    <= 2'd0;
      head     <= 1'b0;
      // The in-flight response, if it is not arriving now, must be discarded.
      state    <= (outstanding & ~resp) ? DRAIN : IDLE;
    end else begin
      if (req) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_pc   <= fetch_pc;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
      head  <= head ^ pop;
      case (state)
        IDLE:    if (req) state <= WAIT;
        WAIT:    if (resp && !req) state <= IDLE;
        DRAIN:   if (resp) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: queue storage has no reset; count gates every read, so the data
  // contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]    <= req_pc;
      q_instr[tail] <= imem_rdata_i;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    en_o          = 1'b0;
    instruction_o = NOP_INSTR;
    pc_o          = 32'd0;
    if (pop) begin
      en_o          = 1'b1;
      instruction_o = q_instr[head];
      pc_o          = q_pc[head];
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (en_o)              fetch_cnt  <= fetch_cnt + 32'd1;
      if (!en_o && !stall_i) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign fetch_count_o  = fetch_cnt;
  assign bubble_count_o = bubble_cnt;
`else
  assign fetch_count_o  = 32'd0;
  assign bubble_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit with a variable-latency instruction memory
// model and a scoreboard of expected {pc, instruction} deliveries. Expected
// PC streams are queued whenever the bench resets or redirects the fetch
// stage; every en_o strobe pops and compares one entry.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0100;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] JUNK      = 32'hDEAD_BEEF;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        en_o;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic [31:0] fetch_count_o;
  logic [31:0] bubble_count_o;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_rvalid_i  (imem_rvalid_i),
    .imem_rdata_i   (imem_rdata_i),
    .en_o           (en_o),
    .instruction_o  (instruction_o),
    .pc_o           (pc_o),
    .fetch_count_o  (fetch_count_o),
    .bubble_count_o (bubble_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory contents: a fixed function of the address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0F0F_0013;
  endfunction

  // ---------------------------------------------------------------------------
  // Memory model: requests sampled at negedge, responses driven at posedge+1.
  // ---------------------------------------------------------------------------
  int             mem_lat = 1;
  logic           pend = 1'b0;
  int             pend_cnt = 0;
  logic [31:0]    pend_addr = 32'd0;
  logic           stale_armed = 1'b0;
  logic [31:0]    req_log [$];

  initial begin
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (stale_armed) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = JUNK;
      end else if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = word_at(pend_addr);
          pend          = 1'b0;
        end else begin
          imem_rvalid_i = 1'b0;
          imem_rdata_i  = 32'd0;
        end
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'd0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
      end else if (imem_req_o) begin
        check("single_outstanding", {31'd0, pend & ~imem_rvalid_i}, 32'd0);
        req_log.push_back(imem_addr_o);
        pend      = 1'b1;
        pend_addr = imem_addr_o;
        pend_cnt  = mem_lat;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: expected delivery PCs, popped on each en_o.
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q [$];
  int          deliv = 0;

  task automatic expect_stream(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  initial begin
    logic [31:0] exp_pc;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (en_o) begin
          deliv++;
          if (exp_q.size() == 0) begin
            check("unexpected_en", {31'd0, en_o}, 32'd0);
          end else begin
            exp_pc = exp_q.pop_front();
            check("deliver_pc", pc_o, exp_pc);
            check("deliver_instr", instruction_o, word_at(exp_pc));
          end
        end else begin
          check("idle_instr", instruction_o, NOP_INSTR);
          check("idle_pc", pc_o, 32'd0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic inflight_fresh();
    return pend && (pend_cnt == 2) && !imem_rvalid_i;
  endfunction

  task automatic wait_inflight(input string tag);
    for (int i = 0; i < 20 && !inflight_fresh(); i++) step();
    check(tag, {31'd0, inflight_fresh()}, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    int d;
    int n0;
    logic [31:0] exp_fetch;
    logic [31:0] exp_bubble;

`ifdef FETCH_PERF_CNT_EN
    exp_fetch  = 32'd10;
    exp_bubble = 32'd3;
`else
    exp_fetch  = 32'd0;
    exp_bubble = 32'd0;
`endif

    reset         = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    repeat (3) step();
    #1;
    check("rst_en", {31'd0, en_o}, 32'd0);
    check("rst_instr", instruction_o, NOP_INSTR);
    check("rst_pc", pc_o, 32'd0);
    check("rst_req", {31'd0, imem_req_o}, 32'd0);
    check("rst_addr", imem_addr_o, RESET_PC);
    check("rst_fetch_cnt", fetch_count_o, 32'd0);
    check("rst_bubble_cnt", bubble_count_o, 32'd0);
    expect_stream(RESET_PC);

    // Cycle 0: reset released, first request goes out immediately.
    step();
    reset = 1'b0;
    #1;
    check("first_req", {31'd0, imem_req_o}, 32'd1);
    check("first_addr", imem_addr_o, RESET_PC);
    check("c0_en", {31'd0, en_o}, 32'd0);

    for (int c = 1; c < 12; c++) begin
      step();
      #1;
      check("stream_en", {31'd0, en_o}, (c >= 2) ? 32'd1 : 32'd0);
      if (c == 2) check("first_pc", pc_o, RESET_PC);
    end

    // Cycle 12: redirect gives the third unstalled empty cycle.
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_3000;
    expect_stream(32'h0000_3000);
    step();
    redirect_i = 1'b0;
    #1;
    check("perf_fetch", fetch_count_o, exp_fetch);
    check("perf_bubble", bubble_count_o, exp_bubble);
    check("req_log_len", {31'd0, req_log.size() >= 3}, 32'd1);
    check("req0", req_log[0], 32'h0000_0100);
    check("req1", req_log[1], 32'h0000_0104);
    check("req2", req_log[2], 32'h0000_0108);

    // Stall for 4 cycles mid-stream: requests stop, nothing lost after.
    repeat (8) step();
    stall_i = 1'b1;
    n0 = req_log.size();
    d  = deliv;
    #1;
    check("stall_en", {31'd0, en_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      check("stall_en", {31'd0, en_o}, 32'd0);
    end
    step();
    stall_i = 1'b0;
    check("stall_no_req", req_log.size(), n0);
    check("stall_no_deliv", deliv, d);
    repeat (8) step();
    check("stall_resume", {31'd0, deliv >= d + 7}, 32'd1);

    // Redirect to an unaligned target with a 3-cycle request in flight.
    mem_lat = 3;
    repeat (6) step();
    wait_inflight("inflight_before_redirect");
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_2003;
    expect_stream(32'h0000_2000);
    #1;
    check("redirect_no_req", {31'd0, imem_req_o}, 32'd0);
    check("redirect_no_en", {31'd0, en_o}, 32'd0);
    k = req_log.size();
    d = deliv;
    step();
    redirect_i = 1'b0;
    #1;
    check("drain_no_req_a", {31'd0, imem_req_o}, 32'd0);
    step();
    #1;
    check("drain_stale_arrives", {31'd0, imem_rvalid_i}, 32'd1);
    check("drain_no_req_b", {31'd0, imem_req_o}, 32'd0);
    step();
    #1;
    check("target_req", {31'd0, imem_req_o}, 32'd1);
    check("target_addr", imem_addr_o, 32'h0000_2000);
    repeat (20) step();
    check("target_logged", req_log[k], 32'h0000_2000);
    check("target_delivered", {31'd0, deliv > d}, 32'd1);

    // Address wrap at the top of the address space.
    mem_lat = 1;
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    expect_stream(32'hFFFF_FFFC);
    k = req_log.size();
    d = deliv;
    step();
    redirect_i = 1'b0;
    repeat (12) step();
    check("wrap_req_top", req_log[k], 32'hFFFF_FFFC);
    check("wrap_req_zero", req_log[k+1], 32'h0000_0000);
    check("wrap_delivered", {31'd0, deliv >= d + 3}, 32'd1);

    // Reset while a request is in flight; a stale strobe follows release.
    mem_lat = 3;
    wait_inflight("inflight_before_reset");
    reset = 1'b1;
    exp_q.delete();
    step();
    stale_armed = 1'b1;
    #1;
    check("rst2_req", {31'd0, imem_req_o}, 32'd0);
    check("rst2_fetch_cnt", fetch_count_o, 32'd0);
    check("rst2_bubble_cnt", bubble_count_o, 32'd0);
    check("rst2_addr", imem_addr_o, RESET_PC);
    step();
    reset       = 1'b0;
    stale_armed = 1'b0;
    expect_stream(RESET_PC);
    k = req_log.size();
    d = deliv;
    #1;
    check("rst2_restart_req", {31'd0, imem_req_o}, 32'd1);
    check("rst2_restart_addr", imem_addr_o, RESET_PC);
    repeat (20) step();
    check("rst2_logged", req_log[k], RESET_PC);
    check("rst2_delivered", {31'd0, deliv > d}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
